// File: rtl/uc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uc_pkg                                                 |
// | Purpose : Shared types and encodings for the multicycle control  |
// |           unit: state enum, opcodes, ALUOp, MemtoReg, ALUSrcB    |
// |           and PCSource selects.                                  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package uc_pkg;

   // Controller states; EXCEPT is only reachable when UC_EXCEPTION_EN is defined
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_RTYPE    = 4'd2,
      ST_RTYPE_WB = 4'd3,
      ST_MEM_ADDR = 4'd4,
      ST_LW_READ  = 4'd5,
      ST_LW_WB    = 4'd6,
      ST_SW_WRITE = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_ADDI     = 4'd9,
      ST_ADDI_WB  = 4'd10,
      ST_LUI      = 4'd11,
      ST_JUMP     = 4'd12,
      ST_EXCEPT   = 4'd13
   } uc_state_e;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // ALU operation select (low two bits of ALUOp)
   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   // Write-back source
   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_LUI    = 2'd2;

   // ALU B operand source
   localparam logic [1:0] SRCB_REG    = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   // PC source
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_VECTOR = 2'd3;

   // States that stretch by MEM_WAIT extra cycles (memory access states)
   function automatic logic is_multi_cycle(input uc_state_e s);
      return (s == ST_FETCH) || (s == ST_LW_READ) || (s == ST_SW_WRITE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uc_wait_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uc_wait_cnt                                            |
// | Purpose : 4-bit memory wait counter. Held at zero while clear is |
// |           high, counts while enable is high; done flags that the |
// |           count has reached MEM_WAIT.                            |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module uc_wait_cnt #(
   parameter int MEM_WAIT = 0
)(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Next count: clear has priority over counting
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = 4'd0;
      end else if (enable) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == WAIT_LIMIT);

endmodule
`default_nettype wire

// File: rtl/uc_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uc_multi                                               |
// | Purpose : Moore-style control unit for a multicycle MIPS-like    |
// |           datapath with configurable memory wait states.         |
// | Config  : UC_EXCEPTION_EN - adds EXCEPT state and EPCWrite port  |
// |           for unknown opcodes (otherwise they return to FETCH).  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module uc_multi
   import uc_pkg::*;
#(
   parameter int MEM_WAIT = 0,
   parameter int ALUOP_W  = 3
)(
   input  logic               Clk,
   input  logic               Reset,
   input  logic [5:0]         Op,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               PCWriteCondNeg,
   output logic               IorD,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               ALUSrcA,
   output logic               RegWrite,
   output logic               RegDst,
   output logic               AWrite,
   output logic               BWrite,
   output logic               ALUOutWrite,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         PCSource,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
`ifdef UC_EXCEPTION_EN
   output logic               EPCWrite,
`endif
   output logic [3:0]         State
);

   uc_state_e  state_q;
   uc_state_e  state_d;
   logic       wait_done;
   logic       wait_en;
   logic       wait_clr;
   logic [1:0] alu_sel;

   // Count only while stalled in a memory state; otherwise hold at zero so
   // the counter is already clear on entry to the next memory state.
   assign wait_en  = is_multi_cycle(state_q) && !wait_done;
   assign wait_clr = !wait_en;

   uc_wait_cnt #(
      .MEM_WAIT (MEM_WAIT)
   ) u_wait_cnt (
      .clk    (Clk),
      .rst    (Reset),
      .clear  (wait_clr),
      .enable (wait_en),
      .done   (wait_done)
   );

   // Next-state logic; Op is consulted only in DECODE and MEM_ADDR
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:    if (wait_done) state_d = ST_DECODE;
         ST_DECODE: begin
            case (Op)
               OP_RTYPE:      state_d = ST_RTYPE;
               OP_LW, OP_SW:  state_d = ST_MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = ST_BRANCH;
               OP_ADDI:       state_d = ST_ADDI;
               OP_LUI:        state_d = ST_LUI;
               OP_J:          state_d = ST_JUMP;
`ifdef UC_EXCEPTION_EN
               default:       state_d = ST_EXCEPT;
`else
               default:       state_d = ST_FETCH;
`endif
            endcase
         end
         ST_RTYPE:    state_d = ST_RTYPE_WB;
         ST_MEM_ADDR: state_d = (Op == OP_LW) ? ST_LW_READ : ST_SW_WRITE;
         ST_LW_READ:  if (wait_done) state_d = ST_LW_WB;
         ST_SW_WRITE: if (wait_done) state_d = ST_FETCH;
         ST_ADDI:     state_d = ST_ADDI_WB;
         default:     state_d = ST_FETCH;
      endcase
   end

   // State register; reset returns to FETCH from anywhere, including mid-wait
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Output decode from state and wait status; everything forced low in reset
   always_comb begin
      PCWrite        = 1'b0;
      PCWriteCond    = 1'b0;
      PCWriteCondNeg = 1'b0;
      IorD           = 1'b0;
      MemWrite       = 1'b0;
      IRWrite        = 1'b0;
      ALUSrcA        = 1'b0;
      RegWrite       = 1'b0;
      RegDst         = 1'b0;
      AWrite         = 1'b0;
      BWrite         = 1'b0;
      ALUOutWrite    = 1'b0;
      MemtoReg       = M2R_ALUOUT;
      PCSource       = PCSRC_ALU;
      ALUSrcB        = SRCB_REG;
      alu_sel        = ALU_ADD;
`ifdef UC_EXCEPTION_EN
      EPCWrite       = 1'b0;
`endif
      if (!Reset) begin
         case (state_q)
            ST_FETCH: begin
               ALUSrcB = SRCB_FOUR;
               PCWrite = wait_done;
               IRWrite = wait_done;
            end
            ST_DECODE: begin
               AWrite      = 1'b1;
               BWrite      = 1'b1;
               ALUSrcB     = SRCB_IMM_SH;
               ALUOutWrite = 1'b1;
            end
            ST_RTYPE: begin
               ALUSrcA     = 1'b1;
               alu_sel     = ALU_FUNCT;
               ALUOutWrite = 1'b1;
            end
            ST_RTYPE_WB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            ST_MEM_ADDR, ST_ADDI: begin
               ALUSrcA     = 1'b1;
               ALUSrcB     = SRCB_IMM;
               ALUOutWrite = 1'b1;
            end
            ST_LW_READ: begin
               IorD = 1'b1;
            end
            ST_LW_WB: begin
               MemtoReg = M2R_MDR;
               RegWrite = 1'b1;
            end
            ST_SW_WRITE: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
            end
            ST_BRANCH: begin
               ALUSrcA        = 1'b1;
               alu_sel        = ALU_SUB;
               PCSource       = PCSRC_ALUOUT;
               PCWriteCond    = (Op == OP_BEQ);
               PCWriteCondNeg = (Op == OP_BNE);
            end
            ST_ADDI_WB: begin
               RegWrite = 1'b1;
            end
            ST_LUI: begin
               MemtoReg = M2R_LUI;
               RegWrite = 1'b1;
            end
            ST_JUMP: begin
               PCSource = PCSRC_JUMP;
               PCWrite  = 1'b1;
            end
`ifdef UC_EXCEPTION_EN
            ST_EXCEPT: begin
               EPCWrite = 1'b1;
               PCWrite  = 1'b1;
               PCSource = PCSRC_VECTOR;
            end
`endif
            default: ;
         endcase
      end
   end

   // Upper ALUOp bits are always zero
   assign ALUOp = ALUOP_W'(alu_sel);
   assign State = state_q;

endmodule
`default_nettype wire

// File: tb/tb_uc_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_uc_multi                                            |
// | Purpose : Directed self-checking bench for uc_multi; three       |
// |           instances with MEM_WAIT = 0, 2 and 3.                  |
// | Config  : honours UC_EXCEPTION_EN                                |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_uc_multi;
   import uc_pkg::*;

   typedef struct packed {
      logic       pcw, pcwc, pcwcn, iord, memw, irw, srca, regw, regdst, aw, bw, aow;
      logic [1:0] m2r, pcsrc, srcb;
      logic [2:0] aluop;
      logic       epc;
   } ctl_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [3];
   logic [5:0] op  [3];
   logic [3:0] st  [3];
   ctl_t       ctl [3];

   int total = 0;
   int bad   = 0;
   uc_state_e seq[$];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int MW = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
      logic       pcw, pcwc, pcwcn, iord, memw, irw, srca, regw, regdst, aw, bw, aow, epc;
      logic [1:0] m2r, pcsrc, srcb;
      logic [2:0] aluop;
      logic [3:0] state;
      uc_multi #(.MEM_WAIT(MW), .ALUOP_W(3)) u_dut (
         .Clk(clk), .Reset(rst[g]), .Op(op[g]),
         .PCWrite(pcw), .PCWriteCond(pcwc), .PCWriteCondNeg(pcwcn),
         .IorD(iord), .MemWrite(memw), .IRWrite(irw), .ALUSrcA(srca),
         .RegWrite(regw), .RegDst(regdst), .AWrite(aw), .BWrite(bw),
         .ALUOutWrite(aow), .MemtoReg(m2r), .PCSource(pcsrc),
         .ALUSrcB(srcb), .ALUOp(aluop),
`ifdef UC_EXCEPTION_EN
         .EPCWrite(epc),
`endif
         .State(state)
      );
`ifndef UC_EXCEPTION_EN
      assign epc = 1'b0;
`endif
      assign ctl[g] = {pcw, pcwc, pcwcn, iord, memw, irw, srca, regw, regdst,
                       aw, bw, aow, m2r, pcsrc, srcb, aluop, epc};
      assign st[g]  = state;
   end

   function automatic int mw_of(input int g);
      return (g == 0) ? 0 : ((g == 1) ? 2 : 3);
   endfunction

   // Expected control word for a state, written from the control table
   function automatic ctl_t ctl_of(input uc_state_e s, input logic [5:0] o, input bit last);
      ctl_t c = '0;
      case (s)
         ST_FETCH:    begin c.srcb = 2'd1; c.pcw = last; c.irw = last; end
         ST_DECODE:   begin c.aw = 1; c.bw = 1; c.aow = 1; c.srcb = 2'd3; end
         ST_RTYPE:    begin c.srca = 1; c.aluop = 3'd2; c.aow = 1; end
         ST_RTYPE_WB: begin c.regdst = 1; c.regw = 1; end
         ST_MEM_ADDR: begin c.srca = 1; c.srcb = 2'd2; c.aow = 1; end
         ST_LW_READ:  begin c.iord = 1; end
         ST_LW_WB:    begin c.m2r = 2'd1; c.regw = 1; end
         ST_SW_WRITE: begin c.iord = 1; c.memw = 1; end
         ST_BRANCH:   begin c.srca = 1; c.aluop = 3'd1; c.pcsrc = 2'd1;
                            c.pcwc = (o == 6'h04); c.pcwcn = (o == 6'h05); end
         ST_ADDI:     begin c.srca = 1; c.srcb = 2'd2; c.aow = 1; end
         ST_ADDI_WB:  begin c.regw = 1; end
         ST_LUI:      begin c.m2r = 2'd2; c.regw = 1; end
         ST_JUMP:     begin c.pcsrc = 2'd2; c.pcw = 1; end
         ST_EXCEPT:   begin c.epc = 1; c.pcw = 1; c.pcsrc = 2'd3; end
         default: ;
      endcase
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pulse reset for one edge and check the reset state
   task automatic do_reset(input int g, input string name);
      rst[g] = 1'b1;
      @(posedge clk); #1;
      check({name, ".rst.st"}, 32'(st[g]), 32'(ST_FETCH));
      check({name, ".rst.ctl"}, 32'(ctl[g]), 32'h0);
      rst[g] = 1'b0;
   endtask

   // Walk the expected state list one cycle at a time; Op carries a
   // distractor value outside the states that are allowed to look at it
   task automatic run_seq(input int g, input logic [5:0] opc, input string name);
      int cnt = 0;
      bit last;
      for (int i = 0; i < seq.size(); i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         op[g] = (seq[i] inside {ST_DECODE, ST_MEM_ADDR, ST_BRANCH}) ? opc : (opc ^ 6'h15);
         cnt   = (i > 0 && seq[i] == seq[i-1]) ? cnt + 1 : 0;
         last  = (cnt == mw_of(g));
         @(negedge clk);
         check($sformatf("%s.%0d.st", name, i), 32'(st[g]), 32'(seq[i]));
         check($sformatf("%s.%0d.ctl", name, i), 32'(ctl[g]), 32'(ctl_of(seq[i], opc, last)));
      end
   endtask

   initial begin
      for (int g = 0; g < 3; g++) begin
         rst[g] = 1'b1;
         op[g]  = 6'h00;
      end
      repeat (2) @(posedge clk);

      // MEM_WAIT = 0
      do_reset(0, "r0");
      seq = {ST_FETCH, ST_DECODE, ST_RTYPE, ST_RTYPE_WB, ST_FETCH};
      run_seq(0, 6'h00, "r0");
      do_reset(0, "bne0");
      seq = {ST_FETCH, ST_DECODE, ST_BRANCH, ST_FETCH};
      run_seq(0, 6'h05, "bne0");
      do_reset(0, "beq0");
      run_seq(0, 6'h04, "beq0");
      do_reset(0, "addi0");
      seq = {ST_FETCH, ST_DECODE, ST_ADDI, ST_ADDI_WB, ST_FETCH};
      run_seq(0, 6'h08, "addi0");
      do_reset(0, "lui0");
      seq = {ST_FETCH, ST_DECODE, ST_LUI, ST_FETCH};
      run_seq(0, 6'h0F, "lui0");
      do_reset(0, "j0");
      seq = {ST_FETCH, ST_DECODE, ST_JUMP, ST_FETCH};
      run_seq(0, 6'h02, "j0");
      do_reset(0, "sw0");
      seq = {ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_SW_WRITE, ST_FETCH};
      run_seq(0, 6'h2B, "sw0");
      do_reset(0, "lw0");
      seq = {ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_LW_READ, ST_LW_WB, ST_FETCH};
      run_seq(0, 6'h23, "lw0");
      do_reset(0, "bad0");
`ifdef UC_EXCEPTION_EN
      seq = {ST_FETCH, ST_DECODE, ST_EXCEPT, ST_FETCH};
`else
      seq = {ST_FETCH, ST_DECODE, ST_FETCH};
`endif
      run_seq(0, 6'h3F, "bad0");
      rst[0] = 1'b1;

      // MEM_WAIT = 2
      do_reset(1, "lw2");
      seq = {ST_FETCH, ST_FETCH, ST_FETCH, ST_DECODE, ST_MEM_ADDR,
             ST_LW_READ, ST_LW_READ, ST_LW_READ, ST_LW_WB, ST_FETCH};
      run_seq(1, 6'h23, "lw2");
      do_reset(1, "r2");
      seq = {ST_FETCH, ST_FETCH, ST_FETCH, ST_DECODE, ST_RTYPE, ST_RTYPE_WB, ST_FETCH};
      run_seq(1, 6'h00, "r2");
      rst[1] = 1'b1;

      // MEM_WAIT = 3: reset lands in the second SW_WRITE cycle
      do_reset(2, "sw3");
      seq = {ST_FETCH, ST_FETCH, ST_FETCH, ST_FETCH, ST_DECODE, ST_MEM_ADDR,
             ST_SW_WRITE, ST_SW_WRITE};
      run_seq(2, 6'h2B, "sw3");
      rst[2] = 1'b1;
      #1;
      check("sw3.rst_now.memw", 32'(ctl[2].memw), 32'h0);
      check("sw3.rst_now.ctl", 32'(ctl[2]), 32'h0);
      check("sw3.rst_now.st", 32'(st[2]), 32'(ST_SW_WRITE));
      @(posedge clk); #1;
      check("sw3.rst_edge.st", 32'(st[2]), 32'(ST_FETCH));
      rst[2] = 1'b0;
      seq = {ST_FETCH, ST_FETCH, ST_FETCH, ST_FETCH, ST_DECODE, ST_LUI, ST_FETCH};
      run_seq(2, 6'h0F, "lui3");
      rst[2] = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
